// File: rtl/ksz_cmd_queue.sv
// Command FIFO and single-outstanding issuer in front of the KSZ8851 chip interface.
// Queued register/DMA requests go out one at a time and each produces one tagged response.
module ksz_cmd_queue #(
    parameter int DEPTH_LOG2 = 3,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  sysclk,
    input  logic                  reset,
    input  logic                  cmd_wen,
    input  logic                  cmd_isDMA,
    input  logic                  cmd_isWrite,
    input  logic                  cmd_isWord,
    input  logic [7:0]            cmd_addr,
    input  logic [15:0]           cmd_data,
    input  logic [3:0]            cmd_tag,
    input  logic                  flush,
    output logic                  cmd_full,
    output logic [DEPTH_LOG2:0]   cmd_count,
    output logic                  overflow,
    output logic                  cmdReq,
    output logic                  isDMA,
    output logic                  isWrite,
    output logic                  isWord,
    output logic [7:0]            RegAddr,
    output logic [15:0]           DataIn,
    input  logic                  cmdAck,
    input  logic                  dataValid,
    input  logic [15:0]           DataOut,
    input  logic                  ksz_isIdle,
    output logic                  rsp_valid,
    output logic [3:0]            rsp_tag,
    output logic                  rsp_isWrite,
    output logic [15:0]           rsp_data,
    output logic                  rsp_timeout,
    output logic                  busy
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(TIMEOUT);
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef struct packed {
        logic        is_dma;
        logic        is_write;
        logic        is_word;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [3:0]  tag;
    } entry_t;

    typedef enum logic [1:0] {Q_IDLE, Q_REQ, Q_REL} state_t;

    entry_t              mem [DEPTH];
    entry_t              entry_in;
    entry_t              head;
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    tmo_cnt;
    logic [3:0]          fl_tag;
    logic [15:0]         cap_data;
    logic                cap_timeout;
    logic                req_done;
    logic                req_tmo;
    logic                rel_done;

    assign entry_in   = '{is_dma: cmd_isDMA, is_write: cmd_isWrite, is_word: cmd_isWord,
                          addr: cmd_addr, data: cmd_data, tag: cmd_tag};
    assign head       = mem[rd_ptr[DEPTH_LOG2-1:0]];
    assign cmd_count  = wr_ptr - rd_ptr;
    assign cmd_full   = (cmd_count == FULL_CNT);
    assign fifo_empty = (wr_ptr == rd_ptr);
    // Fullness is judged before this cycle's pop; flush swallows both push and pop.
    assign push       = cmd_wen && !cmd_full && !flush;
    assign pop        = (state == Q_IDLE) && !fifo_empty && ksz_isIdle && !flush;
    assign busy       = (state != Q_IDLE);

    always_ff @(posedge sysclk) begin
        if (push) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= entry_in;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            rd_ptr   <= wr_ptr;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (cmd_wen && cmd_full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) state <= Q_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_done  = 1'b0;
        req_tmo   = 1'b0;
        rel_done  = 1'b0;
        case (state)
            Q_IDLE: if (pop) state_nxt = Q_REQ;
            Q_REQ: begin
                // A read is only finished by its data; cmdAck alone is not enough.
                req_done = isWrite ? cmdAck : dataValid;
                req_tmo  = !req_done && (tmo_cnt >= TMO_LAST);
                if (req_done || req_tmo) state_nxt = Q_REL;
            end
            Q_REL: begin
                rel_done = !cmdAck && ksz_isIdle;
                if (rel_done) state_nxt = Q_IDLE;
            end
            default: state_nxt = Q_IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            cmdReq      <= 1'b0;
            isDMA       <= 1'b0;
            isWrite     <= 1'b0;
            isWord      <= 1'b0;
            RegAddr     <= '0;
            DataIn      <= '0;
            fl_tag      <= '0;
            tmo_cnt     <= '0;
            cap_data    <= '0;
            cap_timeout <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_tag     <= '0;
            rsp_isWrite <= 1'b0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                Q_IDLE: begin
                    if (pop) begin
                        isDMA       <= head.is_dma;
                        isWrite     <= head.is_write;
                        isWord      <= head.is_word;
                        RegAddr     <= head.addr;
                        DataIn      <= head.data;
                        fl_tag      <= head.tag;
                        cmdReq      <= 1'b1;
                        tmo_cnt     <= '0;
                        cap_data    <= '0;
                        cap_timeout <= 1'b0;
                    end
                end
                Q_REQ: begin
                    if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + 1'b1;
                    if (req_done) begin
                        cmdReq <= 1'b0;
                        if (!isWrite) cap_data <= DataOut;
                    end else if (req_tmo) begin
                        cmdReq      <= 1'b0;
                        cap_timeout <= 1'b1;
                    end
                end
                Q_REL: begin
                    if (rel_done) begin
                        rsp_valid   <= 1'b1;
                        rsp_tag     <= fl_tag;
                        rsp_isWrite <= isWrite;
                        rsp_data    <= cap_data;
                        rsp_timeout <= cap_timeout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ksz_cmd_queue.sv
// Bench for ksz_cmd_queue: directed scenarios plus randomized traffic against a queue-based model
// of accepted commands, driven by a simple behavioural KSZ8851 responder.
module tb_ksz_cmd_queue;
    localparam int TMO = 1023;

    logic        sysclk = 1'b0;
    logic        reset;
    logic        cmd_wen, cmd_isDMA, cmd_isWrite, cmd_isWord;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic [3:0]  cmd_tag;
    logic        flush;
    logic        cmd_full;
    logic [3:0]  cmd_count;
    logic        overflow;
    logic        cmdReq, isDMA, isWrite, isWord;
    logic [7:0]  RegAddr;
    logic [15:0] DataIn;
    logic        cmdAck, dataValid;
    logic [15:0] DataOut;
    logic        ksz_isIdle;
    logic        rsp_valid;
    logic [3:0]  rsp_tag;
    logic        rsp_isWrite;
    logic [15:0] rsp_data;
    logic        rsp_timeout;
    logic        busy;

    ksz_cmd_queue #(.DEPTH_LOG2(3), .TIMEOUT(TMO)) dut (
        .sysclk(sysclk), .reset(reset),
        .cmd_wen(cmd_wen), .cmd_isDMA(cmd_isDMA), .cmd_isWrite(cmd_isWrite),
        .cmd_isWord(cmd_isWord), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .cmd_tag(cmd_tag), .flush(flush), .cmd_full(cmd_full),
        .cmd_count(cmd_count), .overflow(overflow), .cmdReq(cmdReq),
        .isDMA(isDMA), .isWrite(isWrite), .isWord(isWord), .RegAddr(RegAddr),
        .DataIn(DataIn), .cmdAck(cmdAck), .dataValid(dataValid), .DataOut(DataOut),
        .ksz_isIdle(ksz_isIdle), .rsp_valid(rsp_valid), .rsp_tag(rsp_tag),
        .rsp_isWrite(rsp_isWrite), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
        .busy(busy)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        bit        w;
        bit        word;
        bit        dma;
        bit [7:0]  addr;
        bit [15:0] data;
        bit [3:0]  tag;
    } cmd_t;

    cmd_t        exp_q[$];
    cmd_t        nocmd = '{w: 0, word: 0, dma: 0, addr: 0, data: 0, tag: 0};
    int          n_chk = 0, n_pass = 0;
    int          n_rsp = 0, n_rise = 0, req_len = 0, last_req_len = 0;
    bit          req_q = 0;
    bit          mute = 0, hold = 0, rd_fix_en = 0, ovf_m = 0;
    logic [15:0] rd_fix = 16'h0, rd_ret = 16'h0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, want);
    endtask

    // Per-cycle observation: issued fields match the model head, responses match model order.
    task automatic observe();
        cmd_t c;
        if (cmdReq && !req_q) begin
            n_rise++;
            req_len = 0;
            if (exp_q.size() == 0) check_val("req_unexpected", 1, 0);
            else begin
                c = exp_q[0];
                check_val("req_addr", RegAddr, c.addr);
                check_val("req_data", DataIn, c.data);
                check_val("req_mode", {isDMA, isWrite, isWord}, {c.dma, c.w, c.word});
            end
        end
        if (cmdReq) req_len++;
        if (!cmdReq && req_q) last_req_len = req_len;
        req_q = cmdReq;
        if (rsp_valid) begin
            n_rsp++;
            if (exp_q.size() == 0) check_val("rsp_unexpected", 1, 0);
            else begin
                c = exp_q.pop_front();
                check_val("rsp_tag", rsp_tag, c.tag);
                check_val("rsp_isWrite", rsp_isWrite, c.w);
                check_val("rsp_timeout", rsp_timeout, mute);
                check_val("rsp_data", rsp_data, (c.w || mute) ? 16'h0 : rd_ret);
                if (mute) check_val("tmo_len", last_req_len, TMO);
            end
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
        observe();
    endtask

    task automatic cycle(input bit wen, input cmd_t c, input bit fl);
        int cnt;
        cnt = exp_q.size() - int'(busy);
        cmd_wen = wen; cmd_isDMA = c.dma; cmd_isWrite = c.w; cmd_isWord = c.word;
        cmd_addr = c.addr; cmd_data = c.data; cmd_tag = c.tag; flush = fl;
        if (fl) begin
            if (busy) while (exp_q.size() > 1) void'(exp_q.pop_back());
            else exp_q.delete();
            ovf_m = 0;
        end else if (wen) begin
            if (cnt < 8) exp_q.push_back(c);
            else ovf_m = 1;
        end
        tick();
        cmd_wen = 0;
        flush = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, nocmd, 0);
    endtask

    task automatic wait_rsp(input int target, input int budget, input string tag);
        int n = 0;
        while (n_rsp < target && n < budget) begin
            idle(1);
            n++;
        end
        check_val(tag, n_rsp >= target, 1);
    endtask

    task automatic wait_req(input int budget, input string tag);
        int n = 0;
        while (!cmdReq && n < budget) begin
            idle(1);
            n++;
        end
        check_val(tag, cmdReq, 1);
    endtask

    function automatic cmd_t rand_cmd(input bit [3:0] tag);
        cmd_t c;
        c.w = 1'($urandom); c.word = 1'($urandom); c.dma = 1'($urandom);
        c.addr = 8'($urandom); c.data = 16'($urandom); c.tag = tag;
        return c;
    endfunction

    // Behavioural KSZ8851: acks after a random delay, reads return data a little later.
    initial begin
        int dly;
        bit dv_done;
        dly = 0; dv_done = 0;
        cmdAck = 0; dataValid = 0; DataOut = 0; ksz_isIdle = 1;
        forever begin
            @(negedge sysclk);
            DataOut = 16'($urandom);
            if (cmdReq === 1'b1 && !mute) begin
                if (!cmdAck) begin
                    if (dly == 0) begin cmdAck = 1; dly = $urandom_range(0, 3); end
                    else dly--;
                end else if (!isWrite && !dv_done) begin
                    if (dly == 0) begin
                        DataOut = rd_fix_en ? rd_fix : 16'($urandom);
                        rd_ret = DataOut;
                        dataValid = 1;
                        dv_done = 1;
                    end else dly--;
                end else dataValid = 0;
            end else begin
                dataValid = 0;
                cmdAck = 0;
                dv_done = 0;
                dly = $urandom_range(0, 3);
            end
            ksz_isIdle = !hold && !cmdAck;
        end
    end

    initial begin
        cmd_t c;
        int   r0, rise0, n, cnt_m;
        reset = 1; cmd_wen = 0; cmd_isDMA = 0; cmd_isWrite = 0; cmd_isWord = 0;
        cmd_addr = 0; cmd_data = 0; cmd_tag = 0; flush = 0;
        repeat (3) tick();
        reset = 0;
        check_val("rst_cmdReq", cmdReq, 0);
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_count", cmd_count, 0);
        check_val("rst_full", cmd_full, 0);
        check_val("rst_overflow", overflow, 0);
        check_val("rst_busy", busy, 0);

        // Single write: two-cycle issue latency, release on ack.
        r0 = n_rsp;
        c = '{w: 1, word: 1, dma: 0, addr: 8'h70, data: 16'h1234, tag: 4'd3};
        cycle(1, c, 0);
        check_val("wr_lat1_req", cmdReq, 0);
        check_val("wr_lat1_count", cmd_count, 1);
        idle(1);
        check_val("wr_lat2_req", cmdReq, 1);
        check_val("wr_lat2_count", cmd_count, 0);
        n = 0;
        while (!cmdAck && n < 50) begin idle(1); n++; end
        check_val("wr_ack_seen", cmdAck, 1);
        check_val("wr_req_drop", cmdReq, 0);
        wait_rsp(r0 + 1, 50, "wr_rsp_wait");
        check_val("wr_rsp_tag", rsp_tag, 3);
        check_val("wr_rsp_data", rsp_data, 0);
        check_val("wr_rsp_tmo", rsp_timeout, 0);

        // Word read: ack alone keeps cmdReq up until dataValid.
        r0 = n_rsp;
        rd_fix_en = 1; rd_fix = 16'h8872;
        c = '{w: 0, word: 1, dma: 0, addr: 8'h10, data: 16'h0, tag: 4'd5};
        cycle(1, c, 0);
        n = 0;
        while (!cmdAck && n < 50) begin idle(1); n++; end
        check_val("rd_ack_seen", cmdAck, 1);
        check_val("rd_req_held", cmdReq, 1);
        wait_rsp(r0 + 1, 50, "rd_rsp_wait");
        check_val("rd_rsp_data", rsp_data, 16'h8872);
        check_val("rd_rsp_isWrite", rsp_isWrite, 0);
        check_val("rd_rsp_tag", rsp_tag, 5);
        rd_fix_en = 0;

        // Nine pushes while KSZ is busy: eight kept, one lost, then drained in order.
        hold = 1;
        idle(2);
        r0 = n_rsp;
        for (int i = 0; i < 9; i++) cycle(1, rand_cmd(4'(i)), 0);
        check_val("ovf_count", cmd_count, 8);
        check_val("ovf_full", cmd_full, 1);
        check_val("ovf_flag", overflow, 1);
        check_val("ovf_model_len", exp_q.size(), 8);
        hold = 0;
        wait_rsp(r0 + 8, 400, "ovf_drain_wait");
        idle(10);
        check_val("ovf_rsp_count", n_rsp - r0, 8);
        check_val("ovf_overflow_sticky", overflow, 1);

        // Read never answered: abandoned after TIMEOUT cycles.
        mute = 1;
        r0 = n_rsp;
        c = '{w: 0, word: 0, dma: 1, addr: 8'h22, data: 16'h0, tag: 4'd9};
        cycle(1, c, 0);
        wait_rsp(r0 + 1, TMO + 50, "tmo_rsp_wait");
        check_val("tmo_flag", rsp_timeout, 1);
        check_val("tmo_data", rsp_data, 0);
        mute = 0;

        // Flush with the first of four in flight.
        hold = 1;
        idle(2);
        r0 = n_rsp;
        for (int i = 0; i < 4; i++) cycle(1, rand_cmd(4'(10 + i)), 0);
        hold = 0;
        wait_req(20, "fl_req_wait");
        rise0 = n_rise;
        cycle(0, nocmd, 1);
        check_val("fl_count", cmd_count, 0);
        check_val("fl_full", cmd_full, 0);
        check_val("fl_overflow", overflow, 0);
        wait_rsp(r0 + 1, 50, "fl_rsp_wait");
        check_val("fl_rsp_tag", rsp_tag, 10);
        idle(30);
        check_val("fl_rsp_count", n_rsp - r0, 1);
        check_val("fl_no_reissue", n_rise, rise0);

        // Reset while a command waits in Q_REQ, with a second one queued.
        mute = 1;
        r0 = n_rsp;
        cycle(1, rand_cmd(4'd7), 0);
        cycle(1, rand_cmd(4'd8), 0);
        wait_req(10, "rq_req_wait");
        reset = 1;
        exp_q.delete();
        ovf_m = 0;
        tick();
        reset = 0;
        check_val("rq_cmdReq", cmdReq, 0);
        check_val("rq_count", cmd_count, 0);
        check_val("rq_busy", busy, 0);
        mute = 0;
        idle(20);
        check_val("rq_no_rsp", n_rsp, r0);

        // Randomized traffic with occasional KSZ stalls and flushes.
        for (int i = 0; i < 600; i++) begin
            if (i % 16 == 0) hold = ($urandom_range(0, 3) == 0);
            cycle($urandom_range(0, 2) == 0, rand_cmd(4'($urandom)), $urandom_range(0, 60) == 0);
            cnt_m = exp_q.size() - int'(busy);
            check_val("rnd_count", cmd_count, cnt_m);
            check_val("rnd_full", cmd_full, cnt_m == 8);
            check_val("rnd_overflow", overflow, ovf_m);
        end
        hold = 0;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin idle(1); n++; end
        check_val("rnd_drained", exp_q.size(), 0);
        check_val("rnd_idle_count", cmd_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
